vector_load_store_packed: RTL and testbench

Parametrised successor of the single-element vector load/store unit. Moves one D-element vector between the vector register file and DDR, packing L = DdrDataWidth/ElemWidth elements per DDR word. Sits between the instruction dispatcher (valid/ready) and the DDR port, with one DDR request outstanding at a time. Issues a one-cycle done pulse per completed vector.

---
 rtl/vector_load_store_packed.sv | 223 ++++++++++++++++++++++
 tb/tb_vector_load_store_packed.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_load_store_packed.sv
//------------------------------------------------------------------------------
// Module   : vector_load_store_packed
// Brief    : Moves one D-element vector between the vector register file and
//            DDR, packing DDR_DATA_WIDTH/ELEM_WIDTH elements per DDR word.
//            Optional macro VLS_STRIDE_EN adds stride_i as the word step.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vector_load_store_packed_pkg;
    typedef enum logic [1:0] {
        LDV = 2'b01,
        SV  = 2'b10
    } load_store_operation_t;
endpackage

module vector_load_store_packed
    import vector_load_store_packed_pkg::*;
#(
    parameter int D              = 16,
    parameter int ELEM_WIDTH     = 16,
    parameter int DDR_DATA_WIDTH = 64,
    parameter int DDR_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      in_ready_o,
    input  logic                      in_valid_i,
    input  load_store_operation_t     op_i,
    input  logic [DDR_ADDR_WIDTH-1:0] base_addr_i,
`ifdef VLS_STRIDE_EN
    input  logic [DDR_ADDR_WIDTH-1:0] stride_i,
`endif
    output logic                      done_o,
    output logic [$clog2(D)-1:0]      vector_addr_o,
    input  logic [ELEM_WIDTH-1:0]     vector_r_data_i,
    output logic [ELEM_WIDTH-1:0]     vector_w_data_o,
    output logic                      vector_w_en_o,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_address_o,
    output logic                      ddr_r_en_o,
    input  logic [DDR_DATA_WIDTH-1:0] ddr_r_data_i,
    input  logic                      ddr_r_valid_i,
    output logic                      ddr_w_en_o,
    output logic [DDR_DATA_WIDTH-1:0] ddr_w_data_o,
    input  logic                      ddr_w_done_i
);

    localparam int c_L      = DDR_DATA_WIDTH / ELEM_WIDTH;
    localparam int c_W      = D / c_L;
    localparam int c_LANE_W = (c_L > 1) ? $clog2(c_L) : 1;
    localparam int c_WORD_W = (c_W > 1) ? $clog2(c_W) : 1;
    localparam int c_VA_W   = $clog2(D);

    localparam logic [c_LANE_W-1:0] c_LANE_LAST = c_LANE_W'(c_L - 1);
    localparam logic [c_WORD_W-1:0] c_WORD_LAST = c_WORD_W'(c_W - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LD_REQ    = 3'd1;
    localparam logic [2:0] c_ST_LD_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_LD_UNPACK = 3'd3;
    localparam logic [2:0] c_ST_ST_GATHER = 3'd4;
    localparam logic [2:0] c_ST_ST_WRITE  = 3'd5;
    localparam logic [2:0] c_ST_ST_WAIT   = 3'd6;
    localparam logic [2:0] c_ST_DONE      = 3'd7;

    generate
        if (DDR_DATA_WIDTH % ELEM_WIDTH != 0) begin : g_chk_width
            $error("DDR_DATA_WIDTH must be a multiple of ELEM_WIDTH");
        end
        if (D % c_L != 0) begin : g_chk_length
            $error("D must be a multiple of DDR_DATA_WIDTH/ELEM_WIDTH");
        end
    endgenerate

    logic [2:0]                r_state;
    logic [2:0]                w_state_next;
    logic [c_WORD_W-1:0]       r_word_cnt;
    logic [c_LANE_W-1:0]       r_lane_cnt;
    logic [c_VA_W-1:0]         r_elem_idx;
    logic [DDR_ADDR_WIDTH-1:0] r_addr;
    logic [DDR_ADDR_WIDTH-1:0] w_step;
    logic [DDR_DATA_WIDTH-1:0] r_rd_buf;
    logic [DDR_DATA_WIDTH-1:0] r_wr_buf;
    logic [DDR_DATA_WIDTH-1:0] w_wr_buf_next;
    logic                      w_last_lane;
    logic                      w_last_word;

    assign w_last_lane = (r_lane_cnt == c_LANE_LAST);
    assign w_last_word = (r_word_cnt == c_WORD_LAST);

`ifdef VLS_STRIDE_EN
    logic [DDR_ADDR_WIDTH-1:0] r_stride;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stride <= '0;
        end else if (in_valid_i && (r_state == c_ST_IDLE)) begin
            r_stride <= stride_i;
        end
    end

    assign w_step = r_stride;
`else
    assign w_step = DDR_ADDR_WIDTH'(1);
`endif

    // Gathered elements enter at the top lane so that after L shifts lane 0
    // sits at the bottom of the word.
    generate
        if (c_L > 1) begin : g_multi_lane
            assign w_wr_buf_next = {vector_r_data_i, r_wr_buf[DDR_DATA_WIDTH-1:ELEM_WIDTH]};
        end else begin : g_single_lane
            assign w_wr_buf_next = vector_r_data_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid_i) begin
                    case (op_i)
                        LDV:     w_state_next = c_ST_LD_REQ;
                        SV:      w_state_next = c_ST_ST_GATHER;
                        default: w_state_next = c_ST_DONE;
                    endcase
                end
            end
            c_ST_LD_REQ:  w_state_next = c_ST_LD_WAIT;
            c_ST_LD_WAIT: begin
                if (ddr_r_valid_i) w_state_next = c_ST_LD_UNPACK;
            end
            c_ST_LD_UNPACK: begin
                if (w_last_lane) w_state_next = w_last_word ? c_ST_DONE : c_ST_LD_REQ;
            end
            c_ST_ST_GATHER: begin
                if (w_last_lane) w_state_next = c_ST_ST_WRITE;
            end
            c_ST_ST_WRITE: w_state_next = c_ST_ST_WAIT;
            c_ST_ST_WAIT: begin
                if (ddr_w_done_i) w_state_next = w_last_word ? c_ST_DONE : c_ST_ST_GATHER;
            end
            c_ST_DONE:     w_state_next = c_ST_IDLE;
            default:       w_state_next = c_ST_IDLE;
        endcase
    end

    // Datapath: counters, address accumulator and packing buffers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word_cnt <= '0;
            r_lane_cnt <= '0;
            r_elem_idx <= '0;
            r_addr     <= '0;
            r_rd_buf   <= '0;
            r_wr_buf   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid_i) begin
                        r_addr     <= base_addr_i;
                        r_word_cnt <= '0;
                        r_lane_cnt <= '0;
                        r_elem_idx <= '0;
                    end
                end
                c_ST_LD_WAIT: begin
                    if (ddr_r_valid_i) begin
                        r_rd_buf   <= ddr_r_data_i;
                        r_lane_cnt <= '0;
                    end
                end
                c_ST_LD_UNPACK, c_ST_ST_GATHER: begin
                    r_elem_idx <= r_elem_idx + c_VA_W'(1);
                    if (r_state == c_ST_LD_UNPACK) begin
                        r_rd_buf <= r_rd_buf >> ELEM_WIDTH;
                    end else begin
                        r_wr_buf <= w_wr_buf_next;
                    end
                    if (w_last_lane) begin
                        r_lane_cnt <= '0;
                        if ((r_state == c_ST_LD_UNPACK) && !w_last_word) begin
                            r_word_cnt <= r_word_cnt + c_WORD_W'(1);
                            r_addr     <= r_addr + w_step;
                        end
                    end else begin
                        r_lane_cnt <= r_lane_cnt + c_LANE_W'(1);
                    end
                end
                c_ST_ST_WAIT: begin
                    if (ddr_w_done_i && !w_last_word) begin
                        r_word_cnt <= r_word_cnt + c_WORD_W'(1);
                        r_addr     <= r_addr + w_step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready_o      = (r_state == c_ST_IDLE);
        done_o          = (r_state == c_ST_DONE);
        ddr_r_en_o      = (r_state == c_ST_LD_REQ);
        ddr_w_en_o      = (r_state == c_ST_ST_WRITE);
        vector_w_en_o   = (r_state == c_ST_LD_UNPACK);
        ddr_address_o   = r_addr;
        ddr_w_data_o    = r_wr_buf;
        vector_addr_o   = r_elem_idx;
        vector_w_data_o = r_rd_buf[ELEM_WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: tb/tb_vector_load_store_packed.sv
//------------------------------------------------------------------------------
// Module   : tb_vector_load_store_packed
// Brief    : Directed self-checking bench for vector_load_store_packed
//            (D=8, 16-bit elements, 64-bit DDR words).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vector_load_store_packed;
    import vector_load_store_packed_pkg::*;

    localparam int D  = 8;
    localparam int EW = 16;
    localparam int DW = 64;
    localparam int AW = 32;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  in_ready_o;
    logic                  in_valid_i;
    load_store_operation_t op_i;
    logic [AW-1:0]         base_addr_i;
`ifdef VLS_STRIDE_EN
    logic [AW-1:0]         stride_i;
`endif
    logic                  done_o;
    logic [$clog2(D)-1:0]  vector_addr_o;
    logic [EW-1:0]         vector_r_data_i;
    logic [EW-1:0]         vector_w_data_o;
    logic                  vector_w_en_o;
    logic [AW-1:0]         ddr_address_o;
    logic                  ddr_r_en_o;
    logic [DW-1:0]         ddr_r_data_i;
    logic                  ddr_r_valid_i;
    logic                  ddr_w_en_o;
    logic [DW-1:0]         ddr_w_data_o;
    logic                  ddr_w_done_i;

    always #5 clk = ~clk;

    vector_load_store_packed #(
        .D(D), .ELEM_WIDTH(EW), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .in_ready_o      (in_ready_o),
        .in_valid_i      (in_valid_i),
        .op_i            (op_i),
        .base_addr_i     (base_addr_i),
`ifdef VLS_STRIDE_EN
        .stride_i        (stride_i),
`endif
        .done_o          (done_o),
        .vector_addr_o   (vector_addr_o),
        .vector_r_data_i (vector_r_data_i),
        .vector_w_data_o (vector_w_data_o),
        .vector_w_en_o   (vector_w_en_o),
        .ddr_address_o   (ddr_address_o),
        .ddr_r_en_o      (ddr_r_en_o),
        .ddr_r_data_i    (ddr_r_data_i),
        .ddr_r_valid_i   (ddr_r_valid_i),
        .ddr_w_en_o      (ddr_w_en_o),
        .ddr_w_data_o    (ddr_w_data_o),
        .ddr_w_done_i    (ddr_w_done_i)
    );

    logic [EW-1:0] vreg    [0:D-1];
    logic [DW-1:0] rd_word [0:1];
    logic [AW-1:0] rd_addr [0:7];
    logic [AW-1:0] wr_addr [0:7];
    logic [DW-1:0] wr_data [0:7];
    int n_rd, n_wr, n_vw, done_t, ready_busy;
    int n_checks = 0;
    int n_fail   = 0;

    assign vector_r_data_i = vreg[vector_addr_o];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ddr_inputs();
        ddr_r_valid_i = 1'b0;
        ddr_w_done_i  = 1'b0;
        ddr_r_data_i  = '0;
    endtask

    // Issues one operation and plays DDR with response delay r; cycle 1 is
    // the cycle after the accept edge.
    task automatic run_op(input logic [1:0] op, input logic [AW-1:0] base, input int r,
                          input bit spur_unpack, input bit spur_wdone, input bit hold);
        int rd_t, wd_t;
        n_rd = 0; n_wr = 0; n_vw = 0; done_t = -1; ready_busy = 0;
        rd_t = -1; wd_t = -1;
        in_valid_i  = 1'b1;
        op_i        = load_store_operation_t'(op);
        base_addr_i = base;
        tick();
        if (!hold) in_valid_i = 1'b0;
        for (int t = 1; t <= 200 && done_t < 0; t++) begin
            clear_ddr_inputs();
            if (in_ready_o) ready_busy++;
            if (ddr_r_en_o) begin
                if (n_rd < 8) rd_addr[n_rd] = ddr_address_o;
                n_rd++;
                rd_t = t + r;
            end
            if (ddr_w_en_o) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = ddr_address_o;
                    wr_data[n_wr] = ddr_w_data_o;
                end
                n_wr++;
                wd_t = t + r;
                if (spur_wdone) ddr_w_done_i = 1'b1;
            end
            if (vector_w_en_o) begin
                vreg[vector_addr_o] = vector_w_data_o;
                n_vw++;
                if (spur_unpack) begin
                    ddr_r_valid_i = 1'b1;
                    ddr_r_data_i  = 64'hDEAD_BEEF_CAFE_F00D;
                end
            end
            if (t == rd_t) begin
                ddr_r_valid_i = 1'b1;
                ddr_r_data_i  = rd_word[(n_rd - 1) & 1];
            end
            if (t == wd_t) ddr_w_done_i = 1'b1;
            if (done_o) done_t = t;
            tick();
        end
        clear_ddr_inputs();
        if (!hold) in_valid_i = 1'b0;
    endtask

    task automatic check_loaded(input string tag);
        for (int i = 0; i < D; i++) check_value(tag, 64'(vreg[i]), 64'(i + 1));
    endtask

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        op_i = LDV;
        base_addr_i = '0;
`ifdef VLS_STRIDE_EN
        stride_i = 32'd1;
`endif
        clear_ddr_inputs();
        for (int i = 0; i < D; i++) vreg[i] = '0;
        rd_word[0] = 64'h0004_0003_0002_0001;
        rd_word[1] = 64'h0008_0007_0006_0005;
        repeat (3) tick();

        check_value("reset_in_ready", 64'(in_ready_o), 64'd1);
        check_value("reset_done", 64'(done_o), 64'd0);
        check_value("reset_strobes", {61'd0, vector_w_en_o, ddr_r_en_o, ddr_w_en_o}, 64'd0);
        rst_i = 1'b0;

        // Clean LDV, R=3
        run_op(2'b01, 32'h100, 3, 1'b0, 1'b0, 1'b0);
        check_value("ldv_reads", 64'(n_rd), 64'd2);
        check_value("ldv_addr0", 64'(rd_addr[0]), 64'h100);
        check_value("ldv_addr1", 64'(rd_addr[1]), 64'h101);
        check_value("ldv_vwrites", 64'(n_vw), 64'd8);
        check_value("ldv_done_cycle", 64'(done_t), 64'd17);
        check_loaded("ldv_elem");
        check_value("ldv_idle_after", 64'(in_ready_o), 64'd1);

        // Clean SV, R=2
        for (int i = 0; i < D; i++) vreg[i] = 16'(16'h10 + i);
        run_op(2'b10, 32'h200, 2, 1'b0, 1'b0, 1'b0);
        check_value("sv_writes", 64'(n_wr), 64'd2);
        check_value("sv_addr0", 64'(wr_addr[0]), 64'h200);
        check_value("sv_addr1", 64'(wr_addr[1]), 64'h201);
        check_value("sv_data0", wr_data[0], 64'h0013_0012_0011_0010);
        check_value("sv_data1", wr_data[1], 64'h0017_0016_0015_0014);
        check_value("sv_done_cycle", 64'(done_t), 64'd15);
        check_value("sv_no_vwrite", 64'(n_vw), 64'd0);

        // Spurious read-valid in IDLE, then during every unpack cycle
        ddr_r_valid_i = 1'b1;
        ddr_r_data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        clear_ddr_inputs();
        check_value("spur_idle_ready", 64'(in_ready_o), 64'd1);
        check_value("spur_idle_vw", 64'(vector_w_en_o), 64'd0);
        for (int i = 0; i < D; i++) vreg[i] = '0;
        run_op(2'b01, 32'h100, 3, 1'b1, 1'b0, 1'b0);
        check_loaded("spur_ldv_elem");
        check_value("spur_ldv_done_cycle", 64'(done_t), 64'd17);
        check_value("spur_ldv_reads", 64'(n_rd), 64'd2);

        // Write-done asserted in the ST_WRITE cycle itself
        for (int i = 0; i < D; i++) vreg[i] = 16'(16'h10 + i);
        run_op(2'b10, 32'h200, 2, 1'b0, 1'b1, 1'b0);
        check_value("spur_sv_data0", wr_data[0], 64'h0013_0012_0011_0010);
        check_value("spur_sv_data1", wr_data[1], 64'h0017_0016_0015_0014);
        check_value("spur_sv_done_cycle", 64'(done_t), 64'd15);

        // Reset while waiting for read data; the late response must be dropped
        in_valid_i  = 1'b1;
        op_i        = LDV;
        base_addr_i = 32'h300;
        tick();
        in_valid_i = 1'b0;
        check_value("rst_req", 64'(ddr_r_en_o), 64'd1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_value("rst_ready", 64'(in_ready_o), 64'd1);
        check_value("rst_strobes", {61'd0, vector_w_en_o, ddr_r_en_o, ddr_w_en_o}, 64'd0);
        ddr_r_valid_i = 1'b1;
        ddr_r_data_i  = 64'h1111_2222_3333_4444;
        n_vw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            clear_ddr_inputs();
            if (vector_w_en_o) n_vw++;
        end
        check_value("rst_no_vwrite", 64'(n_vw), 64'd0);
        for (int i = 0; i < D; i++) vreg[i] = 16'(16'h20 + i);
        run_op(2'b10, 32'h40, 1, 1'b0, 1'b0, 1'b0);
        check_value("rst_sv_data0", wr_data[0], 64'h0023_0022_0021_0020);
        check_value("rst_sv_data1", wr_data[1], 64'h0027_0026_0025_0024);
        check_value("rst_sv_addr1", 64'(wr_addr[1]), 64'h41);
        // R=1: W*(L+1+1)+1
        check_value("rst_sv_done_cycle", 64'(done_t), 64'd13);

        // in_valid held high: next accept only in the cycle after done_o
        run_op(2'b01, 32'h500, 1, 1'b0, 1'b0, 1'b1);
        check_value("hold_busy_ready", 64'(ready_busy), 64'd0);
        check_value("hold_done_cycle", 64'(done_t), 64'd13);
        check_value("hold_ready_after_done", 64'(in_ready_o), 64'd1);
        tick();
        in_valid_i = 1'b0;
        check_value("hold_second_accept", 64'(in_ready_o), 64'd0);
        check_value("hold_second_req", 64'(ddr_r_en_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        // Unsupported opcode: done_o in the cycle after accept, idle the next
        run_op(2'b11, 32'h600, 1, 1'b0, 1'b0, 1'b0);
        check_value("noop_done_cycle", 64'(done_t), 64'd1);
        check_value("noop_traffic", 64'(n_rd + n_wr + n_vw), 64'd0);
        check_value("noop_ready", 64'(in_ready_o), 64'd1);

`ifdef VLS_STRIDE_EN
        stride_i = 32'h10;
        run_op(2'b01, 32'hFFFF_FFFF, 2, 1'b0, 1'b0, 1'b0);
        check_value("stride_addr0", 64'(rd_addr[0]), 64'hFFFF_FFFF);
        check_value("stride_addr1", 64'(rd_addr[1]), 64'h0000_000F);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
